// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the pipeline
// WB stage and a queue of long-latency results, and keeps a pending-register
// scoreboard that stalls decode on registers with results still outstanding.
// Latency: the port is driven combinationally; a queued result pops no earlier than
// the cycle after its push, and waits at most STARVE_MAX blocked cycles.
// Backpressure: ll_ready drops when the queue is full; pipe_wb_hold asks WB to
// re-present its write during a forced queue drain.
// Ports: clk/rst; pipe_wb_* (WB request, hold); ll_* (result push, ready, issue);
// id_* (decode query, stall); WB_* (register file write port).
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_wb_hold,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic        ll_issue,
  input  logic [4:0]  ll_issue_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  output logic        id_stall,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_Write_reg,
  output logic [31:0] WB_Write_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   DEPTH_W     = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic [4:0]    q_rd_q   [DEPTH];
  logic [31:0]   q_data_q [DEPTH];
  logic [31:0]   pending_q, pending_d;

  logic        empty, push, pop, pipe_eff;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign empty     = (count_q == '0);
  assign head_rd   = q_rd_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];
  assign pipe_eff  = pipe_wb_en && (pipe_wb_rd != 5'd0);

  // Ready comes from the registered count only, so a full queue never sees a
  // same-cycle pop+push.
  assign ll_ready = !rst && (count_q < DEPTH_W);
  assign push     = ll_valid && ll_ready;

  assign id_stall = !rst && (pending_q[id_rs1] | pending_q[id_rs2] | pending_q[id_rd]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    pop           = 1'b0;
    pipe_wb_hold  = 1'b0;
    WB_RegWrite   = 1'b0;
    WB_Write_reg  = 5'd0;
    WB_Write_data = 32'd0;
    if (!rst) begin
      if (state_q == FORCE) begin
        // Queue head owns the port; the WB instruction is held and retried.
        pipe_wb_hold = 1'b1;
        state_d      = NORMAL;
        starve_d     = '0;
        if (!empty) begin
          pop           = 1'b1;
          WB_RegWrite   = (head_rd != 5'd0);
          WB_Write_reg  = head_rd;
          WB_Write_data = head_data;
        end
      end else begin
        if (pipe_eff) begin
          WB_RegWrite   = 1'b1;
          WB_Write_reg  = pipe_wb_rd;
          WB_Write_data = pipe_wb_data;
        end else if (!empty) begin
          pop           = 1'b1;
          WB_RegWrite   = (head_rd != 5'd0);
          WB_Write_reg  = head_rd;
          WB_Write_data = head_data;
        end
        if (empty || pop) begin
          starve_d = '0;
        end else if (starve_q == STARVE_LAST) begin
          state_d  = FORCE;
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_q[wr_ptr_q]   <= ll_rd;
      q_data_q[wr_ptr_q] <= ll_data;
    end
  end

  // Set is applied after clear so a re-issue in the pop cycle keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (pop)      pending_d[head_rd]     = 1'b0;
    if (ll_issue) pending_d[ll_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_wb_hold;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_stall;
  logic        WB_RegWrite;
  logic [4:0]  WB_Write_reg;
  logic [31:0] WB_Write_data;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_wb_hold(pipe_wb_hold),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_stall(id_stall),
    .WB_RegWrite(WB_RegWrite), .WB_Write_reg(WB_Write_reg), .WB_Write_data(WB_Write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    pipe_wb_en = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    ll_issue = 0; ll_issue_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
    pipe_wb_en = en; pipe_wb_rd = rd; pipe_wb_data = d;
  endtask

  task automatic llq(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ll_valid = v; ll_rd = rd; ll_data = d;
  endtask

  task automatic wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"},   32'(WB_RegWrite), 32'd1);
    chk({tag, "_reg"},  32'(WB_Write_reg), 32'(rd));
    chk({tag, "_data"}, WB_Write_data, d);
  endtask

  initial begin
    idle();
    rst = 1;
    // Reset with active requests present
    pipe(1, 5'd5, 32'h1111_1111);
    llq(1, 5'd7, 32'h1234_5678);
    cyc(); cyc();
    settle();
    chk("rst_we",    32'(WB_RegWrite), 0);
    chk("rst_ready", 32'(ll_ready), 0);
    chk("rst_stall", 32'(id_stall), 0);
    chk("rst_hold",  32'(pipe_wb_hold), 0);
    cyc();
    rst = 0; idle();
    settle();
    chk("post_rst_ready", 32'(ll_ready), 1);
    chk("post_rst_we",    32'(WB_RegWrite), 0);

    // Pipe priority then forced drain
    cyc();
    pipe(1, 5'd5, 32'h1111_1111);
    llq(1, 5'd7, 32'hDEAD_BEEF);
    settle();
    wr("prio_c0", 5'd5, 32'h1111_1111);
    cyc();
    llq(0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      settle();
      wr("prio_pipe", 5'd5, 32'h1111_1111);
      chk("prio_nohold", 32'(pipe_wb_hold), 0);
      cyc();
    end
    settle();
    chk("force_hold", 32'(pipe_wb_hold), 1);
    wr("force", 5'd7, 32'hDEAD_BEEF);
    cyc();
    settle();
    chk("resume_hold", 32'(pipe_wb_hold), 0);
    wr("resume", 5'd5, 32'h1111_1111);
    cyc();
    idle();

    // Idle drain, no bypass
    cyc();
    llq(1, 5'd3, 32'hA);
    settle();
    chk("drain_nobypass", 32'(WB_RegWrite), 0);
    cyc();
    llq(1, 5'd4, 32'hB);
    settle();
    wr("drain_x3", 5'd3, 32'hA);
    cyc();
    llq(0, 0, 0);
    settle();
    wr("drain_x4", 5'd4, 32'hB);
    cyc();
    settle();
    chk("drain_empty", 32'(WB_RegWrite), 0);

    // Full queue while the pipe occupies the port
    cyc();
    pipe(1, 5'd5, 32'h5555);
    llq(1, 5'd10, 32'h100);
    settle();
    chk("full_rdy0", 32'(ll_ready), 1);
    cyc();
    llq(1, 5'd11, 32'h200);
    settle();
    chk("full_rdy1", 32'(ll_ready), 1);
    cyc();
    llq(1, 5'd12, 32'h300);
    for (int i = 2; i <= 4; i++) begin
      settle();
      chk("full_rdy_low", 32'(ll_ready), 0);
      wr("full_pipe", 5'd5, 32'h5555);
      cyc();
    end
    settle();
    chk("full_force_hold", 32'(pipe_wb_hold), 1);
    chk("full_force_rdy", 32'(ll_ready), 0);
    wr("full_a", 5'd10, 32'h100);
    cyc();
    settle();
    chk("full_rdy_back", 32'(ll_ready), 1);
    wr("full_pipe2", 5'd5, 32'h5555);
    cyc();
    idle();
    settle();
    wr("full_b", 5'd11, 32'h200);
    cyc();
    settle();
    wr("full_c", 5'd12, 32'h300);
    cyc();
    settle();
    chk("full_empty", 32'(WB_RegWrite), 0);

    // Scoreboard via rs1
    cyc();
    ll_issue = 1; ll_issue_rd = 5'd9; id_rs1 = 5'd9;
    settle();
    chk("sb_rs1_c0", 32'(id_stall), 0);
    cyc();
    ll_issue = 0;
    settle();
    chk("sb_rs1_c1", 32'(id_stall), 1);
    cyc();
    llq(1, 5'd9, 32'h99);
    settle();
    chk("sb_rs1_c2", 32'(id_stall), 1);
    cyc();
    llq(0, 0, 0);
    settle();
    wr("sb_pop9", 5'd9, 32'h99);
    chk("sb_rs1_popcyc", 32'(id_stall), 1);
    cyc();
    settle();
    chk("sb_rs1_clear", 32'(id_stall), 0);

    // Scoreboard via rd, with a re-issue in the pop cycle
    cyc();
    id_rs1 = 0; id_rd = 5'd9;
    ll_issue = 1; ll_issue_rd = 5'd9;
    settle();
    chk("sb_rd_c0", 32'(id_stall), 0);
    cyc();
    ll_issue = 0;
    llq(1, 5'd9, 32'h1);
    settle();
    chk("sb_rd_c1", 32'(id_stall), 1);
    cyc();
    llq(0, 0, 0);
    ll_issue = 1; ll_issue_rd = 5'd9;
    settle();
    wr("sb_rd_pop", 5'd9, 32'h1);
    chk("sb_rd_popcyc", 32'(id_stall), 1);
    cyc();
    ll_issue = 0;
    llq(1, 5'd9, 32'h2);
    settle();
    chk("sb_setwins", 32'(id_stall), 1);
    cyc();
    llq(0, 0, 0);
    settle();
    wr("sb_rd_pop2", 5'd9, 32'h2);
    cyc();
    settle();
    chk("sb_rd_clear", 32'(id_stall), 0);

    // x0 never stalls
    cyc();
    idle();
    ll_issue = 1; ll_issue_rd = 5'd0;
    cyc();
    ll_issue = 0;
    settle();
    chk("sb_x0", 32'(id_stall), 0);

    // x0 handling
    cyc();
    llq(1, 5'd2, 32'h5);
    settle();
    chk("x0_push", 32'(WB_RegWrite), 0);
    cyc();
    llq(0, 0, 0);
    pipe(1, 5'd0, 32'h77);
    settle();
    wr("x0_pipe_x2", 5'd2, 32'h5);
    chk("x0_hold", 32'(pipe_wb_hold), 0);
    cyc();
    settle();
    chk("x0_pipe_nowr", 32'(WB_RegWrite), 0);
    cyc();
    pipe(0, 0, 0);
    llq(1, 5'd0, 32'h9);
    cyc();
    llq(1, 5'd6, 32'h66);
    settle();
    chk("x0_q_nowr", 32'(WB_RegWrite), 0);
    cyc();
    llq(0, 0, 0);
    settle();
    wr("x0_q_next", 5'd6, 32'h66);

    // Reset mid-operation drops queued result and pending bit
    cyc();
    pipe(1, 5'd5, 32'h1);
    llq(1, 5'd8, 32'h88);
    ll_issue = 1; ll_issue_rd = 5'd8;
    id_rd = 5'd8;
    settle();
    wr("mid_pipe", 5'd5, 32'h1);
    cyc();
    rst = 1;
    settle();
    chk("mid_rst_we", 32'(WB_RegWrite), 0);
    chk("mid_rst_stall", 32'(id_stall), 0);
    chk("mid_rst_rdy", 32'(ll_ready), 0);
    cyc();
    rst = 0;
    idle();
    id_rd = 5'd8;
    settle();
    chk("mid_after_we", 32'(WB_RegWrite), 0);
    chk("mid_after_stall", 32'(id_stall), 0);
    chk("mid_after_rdy", 32'(ll_ready), 1);
    cyc();
    settle();
    chk("mid_after_we2", 32'(WB_RegWrite), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and pending-register scoreboard for the single-write-port 32x32 register file. It shares the one write port between the in-order pipeline writeback stage and a long-latency result source (divider/load return) via a small result queue. It tracks destination registers with outstanding long-latency results and produces decode-stage stall signals. It sits between the WB stage and the register file write port, with the scoreboard query driven from ID.

## Interface
- `DEPTH`, 2: long-latency result queue entries (power of two, ≥2).
- `STARVE_MAX`, 4: cycles a queued result may wait before forcing the port.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `pipe_wb_en` in 1: pipeline WB write request.
- `pipe_wb_rd` in 5: pipeline destination register.
- `pipe_wb_data` in 32: pipeline write data.
- `pipe_wb_hold` out 1: pipeline must hold its WB instruction this cycle; its write is not taken.
- `ll_valid` in 1: long-latency result valid.
- `ll_rd` in 5: long-latency destination register.
- `ll_data` in 32: long-latency result data.
- `ll_ready` out 1: queue can accept.
- `ll_issue` in 1: long-latency op dispatched this cycle.
- `ll_issue_rd` in 5: its destination register.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: decode-stage operand and destination registers.
- `id_stall` out 1: decode instruction touches a pending register.
- `WB_RegWrite` out 1: register file write enable.
- `WB_Write_reg` out 5: register file write address.
- `WB_Write_data` out 32: register file write data.

## Operation
- The queue is a FIFO of {rd, data}, DEPTH entries, with wrapping read and write pointers and a count register.
  - `ll_ready` = count < DEPTH, forced 0 during rst.
  - Push on `ll_valid && ll_ready`.
- An effective pipe write is `pipe_wb_en && pipe_wb_rd != 0`.
- State machine, states NORMAL and FORCE:
  - NORMAL: an effective pipe write drives the port. Otherwise the queue head drives the port (if non-empty) and pops. `pipe_wb_hold` = 0.
  - The starve counter increments each cycle the queue is non-empty and no pop occurs. It clears on pop or when the queue is empty.
  - When the counter equals STARVE_MAX-1 and the head is blocked again, the next state is FORCE.
  - FORCE: the head drives the port and pops. `pipe_wb_hold` = 1. The pipe request is ignored; upstream re-presents it next cycle. Next state is NORMAL, and the counter clears.
- Queue entries with rd = 0 still pop but drive `WB_RegWrite` = 0.
- An effective pipe write never drives `WB_RegWrite` for x0.
- Scoreboard: 32-bit `pending`, bit 0 hard-wired 0.
  - Set bit `ll_issue_rd` on `ll_issue`.
  - Clear bit rd when a queue entry with that rd pops.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Only one outstanding result per rd is allowed; this is enforced through `id_stall`.
- `id_stall` = `pending[id_rs1] | pending[id_rs2] | pending[id_rd]`, combinational from registered `pending`. Pop-cycle clears take effect the following cycle.
- The port is driven combinationally from the current pipe inputs or the queue head. This gives same-cycle writeback for the pipe and a write on the first free cycle for a queued result.

## Timing
- Reset (sync, one cycle): queue empty, pointers 0, counter 0, state NORMAL, `pending` = 0.
  - Outputs during and after rst: `WB_RegWrite`=0, `ll_ready`=0 during rst, `pipe_wb_hold`=0, `id_stall`=0.
- A reset mid-operation discards queued results and pending bits; no write is issued in the reset cycle.
- Push-to-write latency: at least 1 cycle. A result pushed in cycle N is eligible to pop in cycle N+1.
- Worst-case wait for a queued head: STARVE_MAX cycles blocked, then written in the FORCE cycle.
- Full queue: `ll_ready`=0 and the producer holds. A pop and a push in the same cycle on a full queue is not allowed, because `ll_ready` is registered-count based.
- Empty queue with a push: the entry is not written the same cycle (no bypass).
- Pointer wrap: at DEPTH, modulo.
- Count arithmetic: count width is log2(DEPTH)+1 bits; counter width covers STARVE_MAX.

## Test plan
- **Reset:** assert rst with `ll_valid`=1 and `pipe_wb_en`=1 → `WB_RegWrite`=0, `ll_ready`=0, `id_stall`=0. The cycle after deassert, `ll_ready`=1.
- **Pipe priority:** pipe writes x5=0x11111111 every cycle; push LL x7=0xDEADBEEF → x5 written for 4 cycles. Cycle 5 is FORCE: `pipe_wb_hold`=1 and x7=0xDEADBEEF is written. The next cycle x5 resumes.
- **Idle drain:** no pipe writes; push x3=0xA, x4=0xB back-to-back → writes x3 then x4 on consecutive cycles starting 1 cycle after the first push.
- **Full queue:** block the port continuously (STARVE_MAX large); push 3 results with DEPTH=2 → `ll_ready`=0 after 2 pushes. The third result is written last, in order, with no loss.
- **Scoreboard:** `ll_issue` rd=9; decode with rs1=9 → `id_stall`=1 until the cycle after x9's pop, then 0. Decode with rd=9 stalls identically. rd=0 never stalls.
- **x0 handling:** pipe write to x0 plus queued x2=0x5 → `WB_RegWrite`=0 for x0 and the x2 entry pops that same cycle. A queued entry with rd=0 pops with no write.
